ksa: RTL
========

# ksa

Key-scheduling stage of the ARC4 datapath, placed directly downstream of the S-memory initialiser (S[i] = i). Once the initialiser reports done, the top-level controller starts this block with a 24-bit key. It runs the ARC4 key-scheduling permutation in place over the 256-byte S memory through the shared single-port RAM interface. It then reports done to the PRGA stage through the same rdy/en handshake.

## Interface
- KEY_BYTES, 3: key length in bytes; key bus width is 8*KEY_BYTES.
- S_DEPTH, 256: S-memory depth; i and j are 8 bits wide.

Ports:
- clk  in  1  single clock; everything changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  24  ARC4 key; key[23:16] is key byte 0, key[7:0] is key byte 2.
- addr  out  8  S-memory address.
- rddata  in  8  S-memory read data, valid the cycle after addr is presented with wren=0.
- wrdata  out  8  S-memory write data.
- wren  out  1  S-memory write enable; the write occurs at the end of the cycle.

## Operation
- Algorithm: j=0; for i in 0..255: j = (j + S[i] + key[i mod 3]) mod 256; swap S[i], S[j].
- Accept: a rising edge with rdy=1 and en=1 latches key into an internal register, clears i, j and the key-byte index, and enters RD_I.
  - Key changes after accept have no effect.
- en while busy: ignored, not queued.
- States and transitions (one cycle each):
  - IDLE: rdy=1, wren=0. Go to RD_I on accept.
  - RD_I: addr=i, wren=0.
  - CALC_J: latch si=rddata. Update j = j + rddata + keybyte (8-bit wrap, carries discarded).
  - RD_J: addr=j (new value), wren=0.
  - WAIT_J: latch sj=rddata; addr=j held.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1.
    - If i==255, go to IDLE.
    - Otherwise i+=1, advance the key-byte index 0→1→2→0, and go to RD_I.
- Key-byte index: a 2-bit counter wrapping at 2. No modulo hardware.
- i==j: both writes target the same address and the second write stores si. The location ends with its original value, which is correct.
- i wrap: i is never incremented past 255. Termination is on the compare, not on overflow.
- Outputs are decoded from registered state, i, j, si and sj only, with no combinational path from en or rddata to any output.

## Timing
- Reset values: rdy=1, wren=0, addr=0, wrdata=0; state IDLE, i=j=0.
- Reset mid-operation returns to IDLE on the next edge with wren=0. Memory contents already written are not restored.
- Per-index cost is 6 cycles. rdy is low for exactly 1536 cycles, starting the cycle after the accept edge, and is high again in cycle 1537.
- Exactly 512 write cycles per run, with at most one wren=1 per cycle.
- A new en may be accepted in the first cycle rdy is high again (back-to-back runs).

## Structure
- Shared package arc4_pkg:
  - ksa_state_t enum (IDLE, RD_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J).
  - S_DEPTH, KEY_BYTES, KEY_W=24, ADDR_W=8, DATA_W=8.
  - The same constants are used by the initialiser and the PRGA.
- No sub-module. A single FSM plus datapath registers (i, j, si, sj, key register, key-byte index).
- The bench instantiates a behavioural 256x8 RAM model with 1-cycle read latency.

## Test plan
- Reset then idle: rst=1 for 2 cycles → rdy=1, wren=0, addr=0. With en=0 for 50 cycles, no wren pulse occurs.
- Key 24'h00033C on S[i]=i memory:
  - After i=1: S[1]=4 and S[4]=1.
  - After i=2 (j=66): S[2]=66 and S[66]=2.
  - rdy returns 1536 cycles after accept.
  - The final S matches the software-model permutation and is a permutation of 0..255.
- Key 24'h000000: i=1 gives j=1 (self-swap, S[1]=1 unchanged). i=2 gives j=3, so S[2]=3 and S[3]=2. The full result matches the model.
- Busy robustness:
  - Toggle en and change key every cycle while rdy=0. The result is identical to the undisturbed 24'h00033C run.
  - Exactly 512 wren cycles are counted.
- Reset mid-run: assert rst at cycle 700 → next edge rdy=1, wren=0. Re-init memory, then start with key 24'h00033C; the result equals the clean run.
- Back-to-back: assert en in the first rdy=1 cycle after a run finishes → accepted immediately. The second run applies KSA on top of the first result, matching the model.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 datapath definitions.
//
// Constants used by the S-memory initialiser, the key-scheduling stage (ksa)
// and the PRGA, plus the ksa state encoding and its register bundle. Keeping
// every ksa register in one struct makes the complete block state visible
// as a single signal.
package arc4_pkg;

    localparam int S_DEPTH   = 256;
    localparam int KEY_BYTES = 3;
    localparam int KEY_W     = 24;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        CALC_J = 3'd2,
        RD_J   = 3'd3,
        WAIT_J = 3'd4,
        WR_I   = 3'd5,
        WR_J   = 3'd6
    } ksa_state_t;

    // Full architectural state of the ksa block.
    typedef struct packed {
        ksa_state_t        state;
        logic [ADDR_W-1:0] i;
        logic [ADDR_W-1:0] j;
        logic [DATA_W-1:0] si;
        logic [DATA_W-1:0] sj;
        logic [1:0]        kidx;
        logic [KEY_W-1:0]  key;
    } ksa_regs_t;

    localparam ksa_regs_t KSA_RESET = '{
        state: IDLE,
        i:     '0,
        j:     '0,
        si:    '0,
        sj:    '0,
        kidx:  '0,
        key:   '0
    };

    // Key byte 0 is the most significant byte of the key bus.
    function automatic logic [DATA_W-1:0] key_byte(input logic [KEY_W-1:0] k,
                                                   input logic [1:0]       idx);
        logic [DATA_W-1:0] b;
        case (idx)
            2'd0:    b = k[23:16];
            2'd1:    b = k[15:8];
            default: b = k[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage.
//
// Runs j = j + S[i] + key[i mod 3]; swap(S[i], S[j]) for i = 0..255 in place
// over the 256-byte S memory through a single-port RAM with 1-cycle read
// latency. Each index costs 6 cycles (RD_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J),
// so a run keeps rdy low for 1536 cycles.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   start request
//   rdy     out  idle, able to accept en
//   key     in   24-bit key, key[23:16] = key byte 0
//   addr    out  S-memory address
//   rddata  in   S-memory read data (valid the cycle after addr, wren=0)
//   wrdata  out  S-memory write data
//   wren    out  S-memory write enable (write at end of cycle)
//
// Handshake: rdy=1 only in IDLE. A rising edge with rdy=1 and en=1 is an
// accept: key is captured and the run starts. en is ignored while rdy=0
// (not queued); the same rdy/en pair signals completion to the next stage.
module ksa
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rddata,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren
);

    ksa_regs_t r;
    ksa_regs_t r_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= KSA_RESET;
        end else begin
            r <= r_nxt;
        end
    end

    always_comb begin
        r_nxt = r;
        case (r.state)
            IDLE: begin
                if (en) begin
                    r_nxt.key   = key;
                    r_nxt.i     = '0;
                    r_nxt.j     = '0;
                    r_nxt.kidx  = '0;
                    r_nxt.state = RD_I;
                end
            end
            RD_I: r_nxt.state = CALC_J;
            CALC_J: begin
                r_nxt.si    = rddata;
                // 8-bit sum: carries out of bit 7 are the mod-256 wrap.
                r_nxt.j     = r.j + rddata + key_byte(r.key, r.kidx);
                r_nxt.state = RD_J;
            end
            RD_J: r_nxt.state = WAIT_J;
            WAIT_J: begin
                r_nxt.sj    = rddata;
                r_nxt.state = WR_I;
            end
            WR_I: r_nxt.state = WR_J;
            WR_J: begin
                // Terminate on the compare so i never wraps past 255.
                if (r.i == ADDR_W'(S_DEPTH - 1)) begin
                    r_nxt.state = IDLE;
                end else begin
                    r_nxt.i     = r.i + 1'b1;
                    r_nxt.kidx  = (r.kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : r.kidx + 2'd1;
                    r_nxt.state = RD_I;
                end
            end
            default: r_nxt.state = IDLE;
        endcase
    end

    // Outputs depend only on registered state. When i == j the WR_J write
    // lands on the same address after WR_I and stores si, leaving the
    // location unchanged.
    always_comb begin
        rdy    = 1'b0;
        addr   = '0;
        wrdata = '0;
        wren   = 1'b0;
        case (r.state)
            IDLE:   rdy  = 1'b1;
            RD_I,
            CALC_J: addr = r.i;
            RD_J,
            WAIT_J: addr = r.j;
            WR_I: begin
                addr   = r.i;
                wrdata = r.sj;
                wren   = 1'b1;
            end
            WR_J: begin
                addr   = r.j;
                wrdata = r.si;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
